// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with a valid/ready handshake.
// Denormal inputs are flushed to zero and results are rounded to nearest, ties to even.
module fp_add_pipe #(
   parameter int EXPBITS  = 8,
   parameter int FRACBITS = 23,
   localparam int W = 1 + EXPBITS + FRACBITS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic [3:0]   flags
);
   localparam int E  = EXPBITS;
   localparam int F  = FRACBITS;
   localparam int XW = F + 4;
   localparam int SW = F + 5;
   localparam int EW = E + 8;
   localparam logic [W-1:0]  QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
   localparam logic [EW-1:0] EXP_MAX = EW'((1 << E) - 1);

   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   logic         sa, sb;
   logic [E-1:0] ea, eb;
   logic [F-1:0] fa, fb;
   logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;

   assign sa     = a[W-1];
   assign sb     = b[W-1] ^ sub;
   assign ea     = a[W-2:F];
   assign eb     = b[W-2:F];
   assign fa     = a[F-1:0];
   assign fb     = b[F-1:0];
   assign a_nan  = (ea == '1) && (fa != '0);
   assign b_nan  = (eb == '1) && (fb != '0);
   assign a_inf  = (ea == '1) && (fa == '0);
   assign b_inf  = (eb == '1) && (fb == '0);
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign swap   = {eb, fb} > {ea, fa};

   // Operand pairs whose result needs no arithmetic are resolved up front and
   // ride down the pipe as a ready-made result.
   logic         s1_spec_n;
   logic [W-1:0] s1_res_n;
   logic [3:0]   s1_flags_n;
   always_comb begin
      s1_spec_n  = 1'b1;
      s1_res_n   = '0;
      s1_flags_n = '0;
      if (a_nan || b_nan)
         s1_res_n = QNAN;
      else if (a_inf && b_inf && (sa != sb)) begin
         s1_res_n   = QNAN;
         s1_flags_n = 4'b1000;
      end
      else if (a_inf)
         s1_res_n = {sa, ea, fa};
      else if (b_inf)
         s1_res_n = {sb, eb, fb};
      else if (a_zero && b_zero)
         s1_res_n = {sa & sb, {(W-1){1'b0}}};
      else if (a_zero)
         s1_res_n = {sb, eb, fb};
      else if (b_zero)
         s1_res_n = {sa, ea, fa};
      else
         s1_spec_n = 1'b0;
   end

   logic         s1_valid, s1_spec, s1_sx, s1_sy;
   logic [W-1:0] s1_res;
   logic [3:0]   s1_flags;
   logic [E-1:0] s1_ex, s1_diff;
   logic [F-1:0] s1_fx, s1_fy;

   logic [XW-1:0] x_al, y_ext, y_al, y_lost;
   logic [SW-1:0] sum_n;
   always_comb begin
      x_al   = {1'b1, s1_fx, 3'b000};
      y_ext  = {1'b1, s1_fy, 3'b000};
      y_lost = '0;
      if (int'(s1_diff) >= XW)
         y_al = XW'(1);
      else begin
         y_al    = y_ext >> s1_diff;
         y_lost  = y_ext & ~({XW{1'b1}} << s1_diff);
         y_al[0] = y_al[0] | (|y_lost);
      end
      if (s1_sx != s1_sy)
         sum_n = {1'b0, x_al} - {1'b0, y_al};
      else
         sum_n = {1'b0, x_al} + {1'b0, y_al};
   end

   logic          s2_valid, s2_spec, s2_sign;
   logic [W-1:0]  s2_res;
   logic [3:0]    s2_flags;
   logic [E-1:0]  s2_exp;
   logic [SW-1:0] s2_sum;

   function automatic logic [6:0] lzc(input logic [XW-1:0] v);
      logic [6:0] n;
      n = 7'(XW);
      for (int i = 0; i < XW; i++)
         if (v[i]) n = 7'(XW - 1 - i);
      return n;
   endfunction

   logic [XW-1:0] norm, shifted;
   logic [6:0]    lz;
   logic [F:0]    mant;
   logic [F+1:0]  mr;
   logic [F-1:0]  frac_n;
   logic [EW-1:0] exp_n;
   logic          g, r, s, rnd, inexact;
   logic [W-1:0]  res_n;
   logic [3:0]    flags_n;
   always_comb begin
      lz      = lzc(s2_sum[XW-1:0]);
      shifted = s2_sum[XW-1:0] << lz;
      if (s2_sum[SW-1]) begin
         norm  = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
         exp_n = EW'(s2_exp) + EW'(1);
      end else begin
         norm  = shifted;
         exp_n = EW'(s2_exp) - EW'(lz);
      end
      mant    = norm[XW-1:3];
      g       = norm[2];
      r       = norm[1];
      s       = norm[0];
      inexact = g | r | s;
      rnd     = g & (r | s | mant[0]);
      mr      = {1'b0, mant} + (F+2)'(rnd);
      frac_n  = mr[F-1:0];
      if (mr[F+1]) begin
         exp_n  = exp_n + EW'(1);
         frac_n = mr[F:1];
      end
      res_n   = {s2_sign, exp_n[E-1:0], frac_n};
      flags_n = {3'b000, inexact};
      // exp_n is two's complement here; a set MSB means it went below zero
      if (s2_spec) begin
         res_n   = s2_res;
         flags_n = s2_flags;
      end
      else if (s2_sum == '0) begin
         res_n   = '0;
         flags_n = '0;
      end
      else if (!exp_n[EW-1] && (exp_n >= EXP_MAX)) begin
         res_n   = {s2_sign, {E{1'b1}}, {F{1'b0}}};
         flags_n = 4'b0101;
      end
      else if (exp_n[EW-1] || (exp_n == '0)) begin
         res_n   = {s2_sign, {(W-1){1'b0}}};
         flags_n = 4'b0011;
      end
   end

   // All three stages advance together on en so bubbles keep their slots.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_spec   <= 1'b0;
         s1_res    <= '0;
         s1_flags  <= '0;
         s1_sx     <= 1'b0;
         s1_sy     <= 1'b0;
         s1_ex     <= '0;
         s1_diff   <= '0;
         s1_fx     <= '0;
         s1_fy     <= '0;
         s2_valid  <= 1'b0;
         s2_spec   <= 1'b0;
         s2_res    <= '0;
         s2_flags  <= '0;
         s2_sign   <= 1'b0;
         s2_exp    <= '0;
         s2_sum    <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end
      else if (en) begin
         s1_valid  <= in_valid;
         s1_spec   <= s1_spec_n;
         s1_res    <= s1_res_n;
         s1_flags  <= s1_flags_n;
         s1_sx     <= swap ? sb : sa;
         s1_sy     <= swap ? sa : sb;
         s1_ex     <= swap ? eb : ea;
         s1_diff   <= swap ? (eb - ea) : (ea - eb);
         s1_fx     <= swap ? fb : fa;
         s1_fy     <= swap ? fa : fb;
         s2_valid  <= s1_valid;
         s2_spec   <= s1_spec;
         s2_res    <= s1_res;
         s2_flags  <= s1_flags;
         s2_sign   <= s1_sx;
         s2_exp    <= s1_ex;
         s2_sum    <= sum_n;
         out_valid <= s2_valid;
         result    <= res_n;
         flags     <= flags_n;
      end
   end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe in single precision: expected results are queued
// as operands are driven and retired in order as the adder produces them.
module tb_fp_add_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags;

   fp_add_pipe #(.EXPBITS(8), .FRACBITS(23)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] r;
      logic [3:0]  f;
   } vec_t;

   // flags are {invalid, overflow, underflow, inexact}
   vec_t vecs [23] = '{
      '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000},
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},
      '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000},
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},
      '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001},
      '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000},
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000},
      '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000},
      '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000},
      '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000},
      '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000},
      '{32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 4'b0000},
      '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011},
      '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000},
      '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000},
      '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'b0001},
      '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001},
      '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101},
      '{32'h3F800000, 32'h00000000, 1'b1, 32'h3F800000, 4'b0000},
      '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000},
      '{32'h7F800000, 32'hFF800001, 1'b0, 32'h7FC00000, 4'b0000}
   };

   logic [35:0] exp_q [$];
   int total = 0;
   int bad = 0;
   int out_idx = 0;
   logic stall_done;

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   // Inputs change only just after a rising edge, so the handshake is settled at the falling edge.
   task automatic apply_stimulus(input vec_t v);
      int waited;
      waited = 0;
      a = v.a;
      b = v.b;
      sub = v.sub;
      in_valid = 1'b1;
      exp_q.push_back({v.r, v.f});
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check_output("accept", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      check_output("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0)
            check_output("spurious_out", 64'(out_valid), 64'd0);
         else
            check_output($sformatf("result[%0d]", out_idx), 64'({result, flags}), 64'(exp_q.pop_front()));
         out_idx++;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      sub = 1'b0;
      out_ready = 1'b1;
      stall_done = 1'b0;
      #12;
      check_output("rst_out_valid", 64'(out_valid), 64'd0);
      check_output("rst_result", 64'(result), 64'd0);
      check_output("rst_flags", 64'(flags), 64'd0);
      check_output("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      apply_stimulus(vecs[0]);
      @(negedge clk);
      check_output("lat_c1", 64'(out_valid), 64'd0);
      @(negedge clk);
      check_output("lat_c2", 64'(out_valid), 64'd0);
      @(negedge clk);
      check_output("lat_c3", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      drain();

      for (int i = 0; i < 23; i++) apply_stimulus(vecs[i]);
      drain();

      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 4; k++) apply_stimulus(vecs[12 + k]);
            stall_done = 1'b1;
         end
      join_none
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk);
         if (n == 3) check_output("stall_ready_before_full", 64'(in_ready), 64'd1);
         if (n >= 4) begin
            check_output("stall_ready", 64'(in_ready), 64'd0);
            check_output("stall_valid", 64'(out_valid), 64'd1);
            check_output("stall_hold", 64'({result, flags}), 64'(exp_q[0]));
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && !stall_done; i++) @(negedge clk);
      check_output("stall_sent", 64'(stall_done), 64'd1);
      drain();

      apply_stimulus(vecs[0]);
      apply_stimulus(vecs[5]);
      apply_stimulus(vecs[13]);
      rst_n = 1'b0;
      #1;
      check_output("midrst_out_valid", 64'(out_valid), 64'd0);
      check_output("midrst_result", 64'(result), 64'd0);
      check_output("midrst_flags", 64'(flags), 64'd0);
      check_output("midrst_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply_stimulus(vecs[15]);
      drain();
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter EXPBITS, default 8, exponent field width (legal range 4..11).
REQ-002 SHALL have parameter FRACBITS, default 23, fraction field width (legal range 4..52).
REQ-003 SHALL derive W = 1+EXPBITS+FRACBITS and BIAS = 2^(EXPBITS-1)-1; operand layout {sign, exp, frac}, sign in MSB.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  operand pair present.
REQ-008 in_ready  out  1  pipeline accepts operands this cycle.
REQ-009 a, b  in  W each  operands.
REQ-010 sub  in  1  1: compute a-b (b sign inverted); 0: compute a+b.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 result  out  W  rounded sum.
REQ-014 flags  out  4  {invalid, overflow, underflow, inexact}.

Function
REQ-015 Transfer occurs on any edge where valid and ready are both 1; in-flight data is carried only through REQ-016 stages.
REQ-016 Three register stages S1/S2/S3; advance enable en = !out_valid || out_ready; in_ready = en, combinationally.
REQ-017 Latency SHALL be exactly 3 cycles from input transfer to out_valid with out_ready held 1; throughput 1 per cycle.
REQ-018 When en=0, all stages hold; result/flags SHALL be stable while out_valid && !out_ready; no loss, duplication or reordering.
REQ-019 Bubbles (stages with valid 0) advance with en and are not collapsed.
REQ-020 S1: classify each operand as zero, denorm, normal, inf or NaN (exp all-ones with frac nonzero = NaN); denorm inputs flushed to signed zero; swap so the larger magnitude is operand X; compute exponent difference.
REQ-021 S2: restore hidden bit; right-shift smaller significand by difference into guard, round and sticky bits; shifts >= FRACBITS+3 leave sticky only; add when effective signs equal, otherwise subtract (X minus Y).
REQ-022 S3: normalise (carry-out: shift right 1, exp+1; cancellation: leading-zero count shift left); round to nearest, ties to even; rounding carry renormalises.
REQ-023 Overflow (final exp >= 2^EXPBITS-1): signed infinity, overflow=1, inexact=1.
REQ-024 Underflow (final exp <= 0, nonzero result): flush to signed zero, underflow=1, inexact=1.
REQ-025 inexact=1 whenever any of guard/round/sticky was nonzero.
REQ-026 Any NaN input: canonical quiet NaN {0, all-ones, 1 then zeros}, invalid=0.
REQ-027 inf + opposite-sign inf (after sub): canonical NaN, invalid=1.
REQ-028 inf with finite or same-sign inf: that inf, flags 0.
REQ-029 Exact cancellation of nonzero values: +0; (-0)+(-0) gives -0; (+0)+(-0) gives +0.
REQ-030 Flags are per-result, not sticky.

Reset
REQ-031 rst_n=0 SHALL immediately clear all stage valids, out_valid=0, result=0, flags=0; in_ready=1 while out_valid=0.
REQ-032 Reset asserted mid-operation discards all in-flight operations; the first result after release belongs to the first post-release transfer.

Verification
REQ-033 a=0x3F800000, b=0x40000000, sub=0, out_ready=1 -> result 0x40400000, flags 0, exactly 3 cycles later.
REQ-034 a=0x3F800000, b=0x3F800000, sub=1 -> result 0x00000000, flags 0; a=b=0x80000000, sub=0 -> 0x80000000.
REQ-035 a=b=0x7F7FFFFF, sub=0 -> 0x7F800000, flags 4'b0101; a=0x7F800000, b=0xFF800000 -> 0x7FC00000, flags 4'b1000.
REQ-036 a=0x3F800000, b=0x33800000 (tie) -> 0x3F800000, inexact=1; b=0x33800001 -> 0x3F800001, inexact=1; a=0x00000001, b=0x3F800000 -> 0x3F800000, flags 0.
REQ-037 Four back-to-back transfers with out_ready=0 for 5 cycles -> in_ready falls after pipeline fills, result held stable, all four results emitted in order once out_ready=1.
REQ-038 rst_n pulsed low with 3 operations in flight -> out_valid=0 at once; no stale result appears after release.
